pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL take parameter ADDR_W, default 16, address/PC width in bits.
REQ-002 SHALL take parameter OFF_W, default 9, signed branch-offset width in half-words.
REQ-003 SHALL take parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 stall  input  1  hold PC this cycle.
REQ-007 branch_en  input  1  current instruction is a branch.
REQ-008 branch_reg  input  1  branch target comes from reg_target, not offset.
REQ-009 cond  input  3  branch condition code.
REQ-010 offset  input  OFF_W  signed half-word offset.
REQ-011 reg_target  input  ADDR_W  register-indirect target.
REQ-012 Z, N, V  input  1 each  zero, negative and overflow flags.
REQ-013 halt_req  input  1  current instruction is HLT.
REQ-014 pc  output  ADDR_W  current PC, registered.
REQ-015 pc_plus2  output  ADDR_W  pc+2, combinational, for link/return use.
REQ-016 taken  output  1  combinational branch-taken decision for the current cycle.
REQ-017 flush  output  1  registered; high one cycle after a redirect is applied.
REQ-018 halted  output  1  registered; high while in HALTED state.

Function
REQ-019 cond_true SHALL decode cond as follows: 000 ~Z; 001 Z; 010 ~Z&~N; 011 N; 100 Z|~N; 101 N|Z; 110 V; 111 1.
REQ-020 taken SHALL equal branch_en & cond_true & (state==RUN).
REQ-021 Arithmetic SHALL be modulo 2^ADDR_W: pc_plus2 = pc+2; imm_target = pc_plus2 + (sign-extended offset << 1); both wrap silently.
REQ-022 target SHALL be reg_target when branch_reg=1, otherwise imm_target.
REQ-023 FSM states SHALL be RUN and HALTED only.
REQ-024 In RUN with stall=0, pend_valid=0 and halt_req=0, pc SHALL load target if taken, otherwise pc_plus2.
REQ-025 In RUN with stall=1, pc SHALL hold its value.
REQ-026 If stall=1, taken=1 and pend_valid=0, target SHALL be latched into pend_addr and pend_valid set to 1.
REQ-027 Later taken branches SHALL be ignored while pend_valid=1.
REQ-028 On the first cycle with stall=0 and pend_valid=1, pc SHALL load pend_addr and pend_valid SHALL clear; that cycle's branch and halt inputs SHALL be ignored.
REQ-029 flush SHALL be 1 in the cycle after any cycle in which pc loaded a taken or pending target, and 0 otherwise.
REQ-030 halt_req=1 in RUN with stall=0 and pend_valid=0 SHALL move the FSM to HALTED; pc holds (not incremented).
REQ-031 halt_req and taken in the same cycle: halt SHALL win, and no redirect or flush SHALL occur.
REQ-032 In HALTED, pc, pend state and flush=0 SHALL hold regardless of inputs; only rst exits HALTED.
REQ-033 halted SHALL be 1 exactly while the state is HALTED.
REQ-034 A branch to its own address (offset = -1) SHALL be legal and repeat every cycle.

Reset
REQ-035 rst=1 SHALL immediately, without a clock edge, force: pc=RESET_VEC, state=RUN, pend_valid=0, pend_addr=0, flush=0, halted=0.
REQ-036 Reset asserted mid-stall or mid-pending SHALL discard the pending target.
REQ-037 The first edge after rst deassertion SHALL perform a normal update.

Verification
REQ-038 Reset then 3 clocks, no branch -> pc sequence 0x0000, 0x0002, 0x0004, 0x0006; flush=0 throughout.
REQ-039 pc=0x0010, branch_en=1, cond=001, Z=1, offset=-3 -> taken=1; next pc=0x000C; flush=1 for one cycle.
REQ-040 pc=0xFFFE, no branch -> next pc=0x0000 (wrap); pc=0x0010, branch_reg=1, cond=111, reg_target=0x1234 -> next pc=0x1234.
REQ-041 Stall and taken branch to 0x0040 for 2 cycles, then stall=0 with a new branch to 0x0080 -> pc holds, then loads 0x0040 (not 0x0080); flush pulses once.
REQ-042 halt_req together with a taken branch at pc=0x0020 -> halted=1, pc stays 0x0020 for 5 clocks; then async rst -> pc=RESET_VEC before the next edge.
REQ-043 Sweep cond 000-111 against all 8 Z/N/V combinations -> taken matches REQ-019 in all 64 cases.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch, conditional/indirect branches,
// stall-deferred redirects and a HALTED state that only reset can leave.
module pc_sequencer #(
  parameter int                 ADDR_W    = 16,
  parameter int                 OFF_W     = 9,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_en,
  input  logic              branch_reg,
  input  logic [2:0]        cond,
  input  logic [OFF_W-1:0]  offset,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              Z,
  input  logic              N,
  input  logic              V,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus2,
  output logic              taken,
  output logic              flush,
  output logic              halted
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   pc_next;
  logic                pend_valid, pend_valid_next;
  logic [ADDR_W-1:0]   pend_addr, pend_addr_next;
  logic                flush_next;
  logic                cond_true;
  logic [ADDR_W-1:0]   off_ext;
  logic [ADDR_W-1:0]   imm_target;
  logic [ADDR_W-1:0]   target;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'b000:  cond_true = ~Z;
      3'b001:  cond_true = Z;
      3'b010:  cond_true = ~Z & ~N;
      3'b011:  cond_true = N;
      3'b100:  cond_true = Z | ~N;
      3'b101:  cond_true = N | Z;
      3'b110:  cond_true = V;
      default: cond_true = 1'b1;
    endcase
  end

  // Offsets count half-words; all sums wrap modulo 2^ADDR_W.
  assign off_ext    = {{(ADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign pc_plus2   = pc + {{(ADDR_W-2){1'b0}}, 2'b10};
  assign imm_target = pc_plus2 + {off_ext[ADDR_W-2:0], 1'b0};
  assign target     = branch_reg ? reg_target : imm_target;
  assign taken      = branch_en & cond_true & (state == RUN);
  assign halted     = (state == HALTED);

  always_comb begin
    state_next      = state;
    pc_next         = pc;
    pend_valid_next = pend_valid;
    pend_addr_next  = pend_addr;
    flush_next      = 1'b0;
    if (state == RUN) begin
      if (stall) begin
        if (taken && !pend_valid) begin
          pend_valid_next = 1'b1;
          pend_addr_next  = target;
        end
      end else if (pend_valid) begin
        // Deferred redirect has priority over whatever is decoded this cycle.
        pc_next         = pend_addr;
        pend_valid_next = 1'b0;
        flush_next      = 1'b1;
      end else if (halt_req) begin
        state_next = HALTED;
      end else if (taken) begin
        pc_next    = target;
        flush_next = 1'b1;
      end else begin
        pc_next = pc_plus2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      pc         <= RESET_VEC;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      flush      <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      pend_valid <= pend_valid_next;
      pend_addr  <= pend_addr_next;
      flush      <= flush_next;
    end
  end

endmodule
